// File: rtl/comparator_serial.sv
// Multi-cycle WIDTH-bit magnitude/equality comparator. It compares CHUNK bits per
// cycle, most-significant chunk first, and stops at the first chunk that differs.
module comparator_serial #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 2,
  localparam int unsigned NCHUNK = WIDTH / CHUNK,
  localparam int unsigned CW = $clog2(NCHUNK + 1)
) (
  input  logic             Clk_CI,
  input  logic             Rst_RBI,
  input  logic [WIDTH-1:0] A_DI,
  input  logic [WIDTH-1:0] B_DI,
  input  logic             Signed_SI,
  input  logic             Valid_SI,
  output logic             Ready_SO,
  output logic             Valid_SO,
  input  logic             Ready_SI,
  output logic             Eq_DO,
  output logic             Lt_DO,
  output logic             Gt_DO,
  output logic [CW-1:0]    Cycles_DO,
  output logic [1:0]       State_DO
);

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("comparator_serial: CHUNK must divide WIDTH and satisfy 1 <= CHUNK <= WIDTH");
  end

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMP  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Flipping the sign bit of both operands maps two's-complement order onto unsigned order.
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt;
  logic             eq_q;
  logic             lt_q;
  logic             gt_q;
  logic [CW-1:0]    cycles_q;

  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic             last_chunk;
  logic [CW-1:0]    cnt_next;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // Ready_SO is high only in IDLE, Valid_SO only in DONE; both are decoded from the
  // registered state, so neither depends combinationally on any input.
  assign Ready_SO  = (state == IDLE);
  assign Valid_SO  = (state == DONE);
  assign Eq_DO     = eq_q;
  assign Lt_DO     = lt_q;
  assign Gt_DO     = gt_q;
  assign Cycles_DO = cycles_q;
  assign State_DO  = state;

  // The operand registers shift left, so the chunk under comparison is always the top one.
  assign chunk_a    = a_q[WIDTH-1 -: CHUNK];
  assign chunk_b    = b_q[WIDTH-1 -: CHUNK];
  assign last_chunk = (cnt == CW'(NCHUNK - 1));
  assign cnt_next   = cnt + CW'(1);

  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cnt      <= '0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
      gt_q     <= 1'b0;
      cycles_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Valid_SI) begin
            a_q   <= A_DI ^ (Signed_SI ? MSB_MASK : '0);
            b_q   <= B_DI ^ (Signed_SI ? MSB_MASK : '0);
            cnt   <= '0;
            state <= CMP;
          end
        end
        CMP: begin
          cnt <= cnt_next;
          if (chunk_a > chunk_b) begin
            gt_q     <= 1'b1;
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
            cycles_q <= cnt_next;
            state    <= DONE;
          end else if (chunk_a < chunk_b) begin
            gt_q     <= 1'b0;
            lt_q     <= 1'b1;
            eq_q     <= 1'b0;
            cycles_q <= cnt_next;
            state    <= DONE;
          end else if (last_chunk) begin
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
            eq_q     <= 1'b1;
            cycles_q <= cnt_next;
            state    <= DONE;
          end else begin
            a_q <= a_q << CHUNK;
            b_q <= b_q << CHUNK;
          end
        end
        DONE: begin
          if (Ready_SI) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_serial.sv
// Bench for comparator_serial: directed cases, backpressure, mid-compare reset,
// back-to-back accepts and random pairs on a 2-bit-chunk and a full-width instance.
module tb_comparator_serial;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // Instance 0: WIDTH=16, CHUNK=2 (8 chunks)
  logic [15:0] a0, b0;
  logic        s0, v0, rdy0, vo0, rsi0, eq0, lt0, gt0;
  logic [3:0]  cyc0;
  logic [1:0]  st0;

  // Instance 1: WIDTH=16, CHUNK=16 (single chunk)
  logic [15:0] a1, b1;
  logic        s1, v1, rdy1, vo1, rsi1, eq1, lt1, gt1;
  logic [0:0]  cyc1;
  logic [1:0]  st1;

  comparator_serial #(.WIDTH(16), .CHUNK(2)) dut0 (
    .Clk_CI(clk), .Rst_RBI(rst_n), .A_DI(a0), .B_DI(b0), .Signed_SI(s0),
    .Valid_SI(v0), .Ready_SO(rdy0), .Valid_SO(vo0), .Ready_SI(rsi0),
    .Eq_DO(eq0), .Lt_DO(lt0), .Gt_DO(gt0), .Cycles_DO(cyc0), .State_DO(st0)
  );

  comparator_serial #(.WIDTH(16), .CHUNK(16)) dut1 (
    .Clk_CI(clk), .Rst_RBI(rst_n), .A_DI(a1), .B_DI(b1), .Signed_SI(s1),
    .Valid_SI(v1), .Ready_SO(rdy1), .Valid_SO(vo1), .Ready_SI(rsi1),
    .Eq_DO(eq1), .Lt_DO(lt1), .Gt_DO(gt1), .Cycles_DO(cyc1), .State_DO(st1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: order from integer values, latency from count of equal leading chunks.
  task automatic ref_cmp(input logic [15:0] a, input logic [15:0] b, input bit s,
                         input int chunk, output logic [31:0] packed_exp);
    longint va, vb;
    int nch, lead, mask, k;
    va = (s && a[15]) ? longint'(a) - 65536 : longint'(a);
    vb = (s && b[15]) ? longint'(b) - 65536 : longint'(b);
    nch = 16 / chunk;
    mask = (1 << chunk) - 1;
    lead = 0;
    for (int i = nch - 1; i >= 0; i--) begin
      if (((int'(a) >> (i * chunk)) & mask) == ((int'(b) >> (i * chunk)) & mask)) lead++;
      else break;
    end
    k = (lead == nch) ? nch : lead + 1;
    packed_exp = {21'd0, 8'(k), va == vb, va < vb, va > vb};
  endtask

  task automatic wait_valid0(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!vo0 && n < 40);
  endtask

  task automatic check_result0(input string tag, input int n);
    logic [31:0] e;
    if (!vo0) begin
      check({tag, "_timeout"}, 32'(vo0), 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_eq"}, 32'(eq0), 32'(e[2]));
    check({tag, "_lt"}, 32'(lt0), 32'(e[1]));
    check({tag, "_gt"}, 32'(gt0), 32'(e[0]));
    check({tag, "_cycles"}, 32'(cyc0), 32'(e[10:3]));
    check({tag, "_latency"}, 32'(n), 32'(e[10:3]));
  endtask

  task automatic run0(input string tag, input logic [15:0] a, input logic [15:0] b, input bit s);
    logic [31:0] e;
    int n;
    n = 0;
    while (!rdy0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    ref_cmp(a, b, s, 2, e);
    exp_q.push_back(e);
    a0 = a; b0 = b; s0 = s; v0 = 1'b1;
    @(posedge clk); #1;
    v0 = 1'b0;
    a0 = 16'($urandom); b0 = 16'($urandom); s0 = 1'($urandom);
    check({tag, "_busy"}, 32'(rdy0), 32'd0);
    wait_valid0(n);
    check_result0(tag, n);
    @(posedge clk); #1;
    check({tag, "_release"}, {30'd0, vo0, rdy0}, 32'd1);
  endtask

  task automatic run1(input logic [15:0] a, input logic [15:0] b, input bit s);
    logic [31:0] e;
    int n;
    ref_cmp(a, b, s, 16, e);
    a1 = a; b1 = b; s1 = s; v1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!vo1 && n < 10);
    if (!vo1) begin
      check("w16_timeout", 32'(vo1), 32'd1);
    end else begin
      check("w16_res", {29'd0, eq1, lt1, gt1}, {29'd0, e[2:0]});
      check("w16_cycles", 32'(cyc1), 32'd1);
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] pick_b(input logic [15:0] a);
    case ($urandom_range(0, 3))
      0: pick_b = 16'($urandom);
      1: pick_b = a;
      2: pick_b = a ^ (16'd1 << $urandom_range(0, 15));
      default: pick_b = a + 16'($urandom_range(0, 4)) - 16'd2;
    endcase
  endfunction

  initial begin
    logic [15:0] ra, rb;
    logic [31:0] e;
    int n, seen;
    rst_n = 1'b0;
    a0 = '0; b0 = '0; s0 = 1'b0; v0 = 1'b0; rsi0 = 1'b1;
    a1 = '0; b1 = '0; s1 = 1'b0; v1 = 1'b0; rsi1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(rdy0), 32'd1);
    check("rst_valid", 32'(vo0), 32'd0);
    check("rst_flags", {29'd0, eq0, lt0, gt0}, 32'd0);
    check("rst_cycles", 32'(cyc0), 32'd0);
    check("rst_ready_w16", 32'(rdy1), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run0("eq1234", 16'h1234, 16'h1234, 1'b0);
    run0("u8000", 16'h8000, 16'h7FFF, 1'b0);
    run0("s8000", 16'h8000, 16'h7FFF, 1'b1);
    run0("sFFFF", 16'hFFFF, 16'h0001, 1'b1);
    run0("u0100", 16'h0100, 16'h0000, 1'b0);
    run0("u00FE", 16'h00FE, 16'h00FF, 1'b0);

    // Backpressure: hold the result while new operands are offered.
    ref_cmp(16'h00FE, 16'h00FF, 1'b0, 2, e);
    exp_q.push_back(e);
    rsi0 = 1'b0;
    a0 = 16'h00FE; b0 = 16'h00FF; s0 = 1'b0; v0 = 1'b1;
    @(posedge clk); #1;
    v0 = 1'b0;
    wait_valid0(n);
    check_result0("bp", n);
    for (int i = 0; i < 5; i++) begin
      v0 = 1'b1; a0 = 16'($urandom); b0 = 16'($urandom); s0 = 1'($urandom);
      @(posedge clk); #1;
      check("bp_valid", 32'(vo0), 32'd1);
      check("bp_ready", 32'(rdy0), 32'd0);
      check("bp_hold", {24'd0, cyc0, 1'b0, eq0, lt0, gt0}, {24'd0, 4'd8, 4'b0010});
    end
    rsi0 = 1'b1; v0 = 1'b0;
    @(posedge clk); #1;
    check("bp_release", {30'd0, vo0, rdy0}, 32'd1);
    @(posedge clk); #1;
    check("bp_not_captured", {30'd0, vo0, rdy0}, 32'd1);

    // Reset on the 3rd compare cycle of an 8-chunk compare.
    a0 = 16'hBEEF; b0 = 16'hBEEF; s0 = 1'b0; v0 = 1'b1;
    @(posedge clk); #1;
    v0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_rst_ready", 32'(rdy0), 32'd1);
    check("mid_rst_valid", 32'(vo0), 32'd0);
    check("mid_rst_results", {28'd0, cyc0 == 4'd0, eq0, lt0, gt0}, 32'h8);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (vo0) seen++;
    end
    check("mid_rst_no_result", 32'(seen), 32'd0);

    // Back-to-back accepts with Valid_SI held high.
    ref_cmp(16'h5A5A, 16'h5A5A, 1'b0, 2, e);
    exp_q.push_back(e);
    ref_cmp(16'h0001, 16'h0002, 1'b0, 2, e);
    exp_q.push_back(e);
    a0 = 16'h5A5A; b0 = 16'h5A5A; s0 = 1'b0; v0 = 1'b1;
    @(posedge clk); #1;
    check("b2b_accept1", 32'(rdy0), 32'd0);
    a0 = 16'h0001; b0 = 16'h0002;
    wait_valid0(n);
    check_result0("b2b_first", n);
    @(posedge clk); #1;
    check("b2b_handshake", {30'd0, vo0, rdy0}, 32'd1);
    @(posedge clk); #1;
    check("b2b_accept2", 32'(rdy0), 32'd0);
    v0 = 1'b0;
    wait_valid0(n);
    check_result0("b2b_second", n);
    @(posedge clk); #1;

    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom);
      rb = pick_b(ra);
      run0("rand", ra, rb, 1'($urandom));
    end

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = pick_b(ra);
      run1(ra, rb, 1'($urandom));
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
